// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver.
//   Synchronises ps2k_clk/ps2k_data, deframes 11-bit frames (start, 8 data LSB first,
//   parity, stop), folds E0/F0 prefixes into ext/brk flags and queues key events in a
//   first-word fall-through FIFO with a valid/ready pop interface.
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   ps2k_clk   PS/2 clock pin (asynchronous)
//   ps2k_data  PS/2 data pin (asynchronous)
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer accepts the head this cycle
//   evt_code   scan code at head (0 when empty)
//   evt_ext    E0 prefix preceded the code (0 when empty)
//   evt_brk    F0 prefix preceded the code (0 when empty)
//   fifo_count number of queued events
//   ovf        sticky: an event was dropped because the FIFO was full
//   frame_err  one-cycle pulse on stop-bit, parity or timeout error
// Configuration:
//   PS2_PARITY_CHECK_EN  when defined, odd parity is checked and a mismatch drops the byte.
module ps2_key_rx #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2k_clk,
  input  logic                        ps2k_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_brk,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        ovf,
  output logic                        frame_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  // Synchronisers. The data chain is one flop shorter so its last stage lines up with
  // clk_sync_q[SYNC_STAGES-2], the newer half of the fall detector.
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-2:0] data_sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
    end else begin
      clk_sync_q[0]  <= ps2k_clk;
      data_sync_q[0] <= ps2k_data;
      for (int i = 1; i < SYNC_STAGES; i++) clk_sync_q[i] <= clk_sync_q[i-1];
      for (int i = 1; i < SYNC_STAGES - 1; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  logic fall, bit_in;
  assign fall   = !clk_sync_q[SYNC_STAGES-2] && clk_sync_q[SYNC_STAGES-1];
  assign bit_in = data_sync_q[SYNC_STAGES-2];

  // Frame FSM and prefix folding.
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic          frame_err_q;
  logic          err, byte_done, push;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_err_d  = par_err_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    err        = 1'b0;
    byte_done  = 1'b0;
    push       = 1'b0;
    tmo_d      = (state_q == StIdle || fall) ? '0 : tmo_q + 1'b1;

    if (state_q != StIdle && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = StIdle;
      tmo_d   = '0;
      err     = 1'b1;
    end else if (fall) begin
      case (state_q)
        StIdle: begin
          if (!bit_in) begin
            state_d   = StData;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
          end
        end
        StData: begin
          shreg_d   = {bit_in, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
`ifdef PS2_PARITY_CHECK_EN
          // Odd parity: data plus parity bit must hold an odd number of ones.
          par_err_d = ~(^{bit_in, shreg_q});
`endif
          state_d = StStop;
        end
        default: begin
          state_d = StIdle;
          if (!bit_in || par_err_q) err = 1'b1;
          else                      byte_done = 1'b1;
        end
      endcase
    end

    if (err) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_done) begin
      if (shreg_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shreg_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        push       = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_err_q   <= 1'b0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_err_q   <= par_err_d;
      tmo_q       <= tmo_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      frame_err_q <= err;
    end
  end

  // Event FIFO: {ext, brk, code}.
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          full, pop, wr_en;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = evt_valid && evt_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ext_pend_q, brk_pend_q, shreg_q};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign evt_valid  = (count_q != '0);
  assign evt_code   = evt_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
  assign evt_brk    = evt_valid ? mem_q[rd_ptr_q][8] : 1'b0;
  assign evt_ext    = evt_valid ? mem_q[rd_ptr_q][9] : 1'b0;
  assign fifo_count = count_q;
  assign ovf        = ovf_q;
  assign frame_err  = frame_err_q;

endmodule
